// File: rtl/conn_sprite_draw.sv
// Sprite draw stage around the 24x24 "connected" ROM: box test, ROM addressing,
// palette-index pipeline and the show/blink sequencer that gates visibility.
module conn_sprite_draw #(
    parameter int SPR_W        = 24,
    parameter int SPR_H        = 24,
    parameter int BLINK_FRAMES = 8,
    parameter int SHOW_PHASES  = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       show,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [5:0] DX,
    output logic [5:0] DY,
    input  logic [7:0] rom_data,
    output logic       pix_valid,
    output logic [7:0] pix_index,
    output logic       busy
);

    // state | meaning
    // IDLE  | no show sequence running, sprite hidden
    // ON    | show sequence running, sprite visible this phase
    // OFF   | show sequence running, sprite hidden this phase
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;

    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int PCW = (SHOW_PHASES > 1) ? $clog2(SHOW_PHASES) : 1;

    logic [1:0]     state;
    logic [FCW-1:0] frame_cnt;
    logic [PCW-1:0] phase_cnt;

    logic [10:0] x_ext, y_ext, px_ext, py_ext;
    logic        inbox;
    logic [5:0]  dx_c, dy_c;
    logic        inbox_d, vis_d;

    // 11-bit compares so a sprite placed near 1023 does not wrap its right/bottom edge
    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        px_ext = {1'b0, pos_x};
        py_ext = {1'b0, pos_y};
        inbox  = (x_ext >= px_ext) && (x_ext < px_ext + 11'(SPR_W)) &&
                 (y_ext >= py_ext) && (y_ext < py_ext + 11'(SPR_H));
        dx_c   = DrawX[5:0] - pos_x[5:0];
        dy_c   = DrawY[5:0] - pos_y[5:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DX      <= '0;
            DY      <= '0;
            inbox_d <= 1'b0;
            vis_d   <= 1'b0;
        end else begin
            DX      <= inbox ? dx_c : 6'd0;
            DY      <= inbox ? dy_c : 6'd0;
            inbox_d <= inbox;
            vis_d   <= (state == ON);
        end
    end

    // ROM index 0 is the transparent colour
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            pix_valid <= inbox_d && vis_d && (rom_data != 8'd0);
            pix_index <= (inbox_d && vis_d && (rom_data != 8'd0)) ? rom_data : 8'd0;
        end
    end

    // show has priority over a coincident frame_start, which is then dropped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            phase_cnt <= '0;
        end else if (show) begin
            state     <= ON;
            frame_cnt <= '0;
            phase_cnt <= '0;
        end else if (frame_start && (state != IDLE)) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                if (phase_cnt == PCW'(SHOW_PHASES - 1)) begin
                    state     <= IDLE;
                    phase_cnt <= '0;
                end else begin
                    phase_cnt <= phase_cnt + 1'b1;
                    state     <= (state == ON) ? OFF : ON;
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_conn_sprite_draw.sv
// Self-checking bench for conn_sprite_draw: pixel pipeline via a two-stage
// scoreboard, box edges, blink sequencing, restart and asynchronous reset.
module tb_conn_sprite_draw;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       show = 1'b0;
    logic [9:0] pos_x = 10'd100;
    logic [9:0] pos_y = 10'd200;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [5:0] DX, DY;
    logic [7:0] rom_data;
    logic       pix_valid;
    logic [7:0] pix_index;
    logic       busy;

    logic       rom_ov_en = 1'b0;
    logic [7:0] rom_ov = 8'd0;
    logic       exp_vis = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0] dx;
        logic [5:0] dy;
        logic       v;
        logic [7:0] idx;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    conn_sprite_draw #(.SPR_W(24), .SPR_H(24), .BLINK_FRAMES(2), .SHOW_PHASES(3)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .show(show),
        .pos_x(pos_x), .pos_y(pos_y), .DrawX(DrawX), .DrawY(DrawY),
        .DX(DX), .DY(DY), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_index(pix_index), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] rom_base(input logic [5:0] dx, input logic [5:0] dy);
        if (dx == 6'd10 && dy == 6'd3) return 8'd1;
        if (dx == 6'd7 && dy == 6'd13) return 8'd5;
        return 8'h40 | {2'b00, dx};
    endfunction

    always_comb rom_data = rom_ov_en ? rom_ov : rom_base(DX, DY);

    // one negedge: retire stage-2 expectation, retire stage-1 expectation, optionally drive new pixel
    task automatic step(input bit drv, input int x, input int y, input int px, input int py);
        exp_t e;
        bit   in;
        logic [7:0] r;
        @(negedge Clk);
        if (q2.size() > 0) begin
            e = q2.pop_front();
            n_cmp++;
            if (pix_valid !== e.v || pix_index !== e.idx) begin
                n_err++;
                $display("FAIL pix: got valid=%0b idx=%0d, want valid=%0b idx=%0d", pix_valid, pix_index, e.v, e.idx);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            n_cmp++;
            if (DX !== e.dx || DY !== e.dy) begin
                n_err++;
                $display("FAIL addr: got DX=%0d DY=%0d, want DX=%0d DY=%0d", DX, DY, e.dx, e.dy);
            end
            q2.push_back(e);
        end
        if (drv) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            pos_x = 10'(px);
            pos_y = 10'(py);
            in = (x >= px) && (x < px + 24) && (y >= py) && (y < py + 24);
            e.dx = in ? 6'(x - px) : 6'd0;
            e.dy = in ? 6'(y - py) : 6'd0;
            r = rom_ov_en ? rom_ov : rom_base(e.dx, e.dy);
            e.v = in && exp_vis && (r != 8'd0);
            e.idx = e.v ? r : 8'd0;
            q1.push_back(e);
        end
    endtask

    task automatic pix(input int x, input int y, input int px, input int py);
        step(1'b1, x, y, px, py);
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_show();
        @(negedge Clk);
        show = 1'b1;
        @(negedge Clk);
        show = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic check_busy(input logic want, input string tag);
        n_cmp++;
        if (busy !== want) begin
            n_err++;
            $display("FAIL busy_%s: got %0b, want %0b", tag, busy, want);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || pix_index !== 8'd0 || DX !== 6'd0 || DY !== 6'd0) begin
            n_err++;
            $display("FAIL reset_values: got busy=%0b valid=%0b idx=%0d DX=%0d DY=%0d, want all 0",
                     busy, pix_valid, pix_index, DX, DY);
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_busy(1'b0, "after_reset");
        exp_vis = 1'b0;
        pix(110, 203, 100, 200);
        flush();
    endtask

    task automatic test_pixels();
        do_show();
        exp_vis = 1'b1;
        check_busy(1'b1, "after_show");
        pix(110, 203, 100, 200);
        pix(107, 213, 100, 200);
        flush();
        rom_ov_en = 1'b1;
        rom_ov = 8'd0;
        pix(100, 200, 100, 200);
        flush();
        rom_ov_en = 1'b0;
    endtask

    task automatic test_edges();
        pix(99, 203, 100, 200);
        pix(124, 203, 100, 200);
        pix(123, 223, 100, 200);
        pix(110, 224, 100, 200);
        pix(110, 199, 100, 200);
        pix(1023, 203, 1020, 200);
        pix(1019, 203, 1020, 200);
        flush();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            pix(int'($urandom_range(90, 130)), int'($urandom_range(190, 230)), 100, 200);
        end
        flush();
    endtask

    task automatic test_blink();
        logic vis_tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k <= 6; k++) begin
            exp_vis = vis_tab[k];
            check_busy(k < 6 ? 1'b1 : 1'b0, $sformatf("blink%0d", k));
            pix(110, 203, 100, 200);
            flush();
            if (k < 6) pulse_frame();
        end
    endtask

    task automatic test_restart();
        logic vis_tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_show();
        repeat (3) pulse_frame();
        @(negedge Clk);
        show = 1'b1;
        frame_start = 1'b1;
        @(negedge Clk);
        show = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            exp_vis = vis_tab[k];
            check_busy(k < 6 ? 1'b1 : 1'b0, $sformatf("restart%0d", k));
            pix(107, 213, 100, 200);
            flush();
            if (k < 6) pulse_frame();
        end
    endtask

    task automatic test_async_reset();
        do_show();
        exp_vis = 1'b1;
        pix(110, 203, 100, 200);
        step(1'b0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0);
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || DX !== 6'd0 || DY !== 6'd0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%0b valid=%0b DX=%0d DY=%0d, want all 0",
                     busy, pix_valid, DX, DY);
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_busy(1'b0, "post_async_reset");
        exp_vis = 1'b0;
        pix(110, 203, 100, 200);
        flush();
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_edges();
        test_back_to_back();
        test_blink();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conn_sprite_draw.md
Name: conn_sprite_draw

Overview:
- Drawing stage directly upstream and downstream of the 24x24 "connected" sprite ROM.
- Converts the VGA scan coordinate and the sprite screen position into ROM row/column addresses (DX/DY), then consumes the returned palette index.
- Emits a pixel-valid flag and a palette index to the colour mapper.
- Owns the show/blink sequencer, which makes the sprite flash for a fixed number of frames after a trigger.

Parameters:
- SPR_W, 24, sprite width in pixels; DX range 0..SPR_W-1.
- SPR_H, 24, sprite height in pixels; DY range 0..SPR_H-1.
- BLINK_FRAMES, 8, frames per on or off phase (>=1).
- SHOW_PHASES, 6, total on+off phases per show sequence (>=1; starts with on).

Ports:
- Clk  in  1  system clock; one clock domain.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse once per frame (vsync edge).
- show  in  1  one-cycle pulse that starts or restarts the show sequence.
- pos_x  in  10  sprite top-left X, screen pixels.
- pos_y  in  10  sprite top-left Y, screen pixels.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- DX  out  6  ROM column address, registered.
- DY  out  6  ROM row address, registered.
- rom_data  in  8  palette index from ROM, combinational from DX/DY.
- pix_valid  out  1  sprite owns this pixel, registered.
- pix_index  out  8  palette index, registered.
- busy  out  1  high while the show sequence is active (state != IDLE).

Behaviour:
- Reset values: DX=0, DY=0, pix_valid=0, pix_index=0, busy=0, state=IDLE, frame_cnt=0, phase_cnt=0.
- Stage 1 (registered at Clk rise):
  - inbox = (DrawX >= pos_x) && (DrawX < pos_x+SPR_W) && (DrawY >= pos_y) && (DrawY < pos_y+SPR_H).
  - Sums use 11-bit arithmetic, so no wrap occurs at pos_x near 1023.
  - When inbox: DX = DrawX-pos_x and DY = DrawY-pos_y (low 6 bits). Otherwise DX=0 and DY=0.
  - Also registers inbox_d and vis_d = (state==ON).
- Stage 2 (registered): pix_valid = inbox_d && vis_d && (rom_data != 0); pix_index = pix_valid ? rom_data : 0.
- Latency: DrawX/DrawY sampled at edge N produce pix_valid/pix_index at edge N+1; two pipeline registers in total.
- ROM index 0 is transparent and is never flagged valid.
- Sequencer state machine, states IDLE, ON, OFF:
  - IDLE: show -> ON, with frame_cnt=0 and phase_cnt=0.
  - ON/OFF: on each frame_start, frame_cnt++.
  - When frame_cnt==BLINK_FRAMES-1 at a frame_start, frame_cnt clears and phase_cnt++.
  - At that same point, if phase_cnt==SHOW_PHASES-1, go to IDLE; otherwise toggle ON<->OFF.
- show while ON/OFF restarts the sequence: state ON, both counters cleared.
- show and frame_start in the same cycle: show wins and that frame_start is not counted.
- Total visible duration: ceil(SHOW_PHASES/2)*BLINK_FRAMES frames on, across SHOW_PHASES*BLINK_FRAMES frames.
- pos_x/pos_y may change at any time and take effect on the next stage-1 sample; there is no per-frame latching.
- Reset mid-sequence returns to IDLE immediately (asynchronously), and pix_valid drops to 0 without waiting for a clock.

Test Plan:
- Reset asserted mid-ON -> busy=0, pix_valid=0, DX=DY=0 immediately; after release, state stays IDLE until show.
- show, pos=(100,200), DrawX=110, DrawY=203:
  - DX=10 and DY=3 one edge later.
  - ROM returns 1, so pix_valid=1 and pix_index=1 one edge after that.
- Same sequence with DrawX=107, DrawY=213 -> DX=7, DY=13, pix_index=5. With DrawX=100, DrawY=200, ROM returns 0 -> pix_valid=0.
- Box edges at pos=(100,200):
  - DrawX=99 or 124 -> DX=0, pix_valid=0.
  - DrawX=123, DrawY=223 -> DX=23, DY=23.
  - pos_x=1020, DrawX=1023 -> inbox, DX=3, no wrap.
- Blink sequence (BLINK_FRAMES=2, SHOW_PHASES=3), show then 6 frame_starts:
  - States follow ON,ON,OFF,OFF,ON,ON, then IDLE after the 6th; busy falls on that edge.
  - In OFF, an in-box non-zero pixel gives pix_valid=0.
- show coincident with frame_start after 3 frames -> counters cleared, state ON, and 6 further frame_starts are needed to reach IDLE.
